pipo_write_arbiter: RTL
=======================

// Module: pipo_write_arbiter
// PURPOSE
//  Shares one N-bit PIPO storage register between M requesters using round-robin arbitration.
//  Each requester raises req and presents its write word; the arbiter grants one owner.
//  It then drives the register's D/EN to load that word and returns a one-cycle ack.
//  Sits between requester blocks and the d_ffN storage register; Q is broadcast to all.
// PARAMETERS
//  N  8  register / data word width (bits)
//  M  4  number of requesters (>=2); owner index width W = $clog2(M)
// PORTS
//  CLK    in   1    system clock, all state updates on posedge
//  Reset  in   1    synchronous, active-high reset
//  req    in   M    req[i]=1: requester i wants a write; held until ack[i]
//  wdata  in   M*N  packed words, requester i at wdata[i*N +: N]
//  gnt    out  M    one-hot grant, high in GRANT and WRITE states
//  ack    out  M    one-hot, one-cycle pulse in ACK: write of owner completed
//  owner  out  W    index of current/last owner
//  busy   out  1    1 whenever state != IDLE
//  Q      out  N    stored register contents
// BEHAVIOUR
//  Clock/reset: one clock CLK; Reset is synchronous and active-high.
//  Reset (any state, incl. mid-transaction), applied at a posedge:
//   - state=IDLE, ptr=0, owner=0, gnt=0, ack=0, busy=0.
//   - Q=0, cleared synchronously by forcing register D=0, EN=1.
//  FSM states: IDLE, GRANT, WRITE, ACK.
//  IDLE:
//   - No req: stay.
//   - Else pick the first set req scanning ptr, ptr+1 .. ptr+M-1 (mod M).
//   - Latch owner=that index; go to GRANT.
//  GRANT:
//   - gnt[owner]=1.
//   - req[owner]=1: go to WRITE.
//   - req[owner]=0 (abort): go to IDLE, no write, ptr=(owner+1)%M.
//  WRITE:
//   - gnt[owner]=1, EN=1, D=wdata[owner].
//   - Register captures the word at the end of this cycle; go to ACK.
//   - req is ignored here; the write cannot be aborted.
//  ACK:
//   - ack[owner]=1; Q already holds the new word.
//   - ptr=(owner+1)%M; go to IDLE.
//  Requester rules:
//   - Requester must drop req the cycle after ack.
//   - A req still high in IDLE is treated as a new request at its rotated priority.
//  Latency: req sampled in IDLE at edge k -> GRANT k, WRITE k+1, Q valid and ack at k+2, IDLE k+3.
//  Throughput: min 4 cycles/write; with all M requesting continuously, each wins once per M writes.
//  EN is 0 in all states except WRITE (and Reset); Q holds its value otherwise.
//  Requests arriving outside IDLE wait; no request is ever lost while req stays high.
//  wdata of non-owners is never sampled; owner data is only sampled during WRITE.
//  gnt and ack are never both set; at most one bit of each is set.
//  Modulo wrap: owner M-1 -> ptr 0.
// STRUCTURE
//  Package pipo_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} arb_state_t.
//   - function next_ptr(owner, M).
//  Sub-module: one d_ffN #(.N(N)) instance for storage.
//   - Its n_Reset is tied 1; reset is done via the D/EN mux above.
//  Arbitration scan, D mux and FSM are inline; all outputs are registered or pure state decode.
// TESTING  (N=8, M=4)
//  1 Reset high 2 cycles during WRITE of 8'hD2 -> Q=0, gnt=0, ack=0, busy=0, ptr=0 next cycle.
//  2 Single: req=4'b0010, wdata[1]=8'hD2 -> gnt=0010 2 cycles, ack=0010 at k+2, Q=8'hD2, busy falls at k+3.
//  3 Contention: req=4'b1111 held, data 8'h11/22/33/44 -> ack order 0,1,2,3,0; Q tracks each.
//  4 Wrap: ptr=3, req=4'b1001 -> owner 3 first, then 0.
//  5 Abort: req[2] dropped in GRANT -> no ack, Q unchanged, next grant goes to index 3 if requesting.
//  6 Hold: after ack, wdata[0]=8'hFF with req=0 -> EN never set, Q keeps last value 20 cycles.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the round-robin PIPO write arbiter.
package pipo_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} arb_state_t;

  function automatic int unsigned next_ptr(input int unsigned owner, input int unsigned m);
    return (owner + 1) % m;
  endfunction

endpackage

// File: rtl/d_ffN.sv
// N-bit parallel-in/parallel-out storage register with load enable.
module d_ffN #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         n_Reset,
  input  logic [N-1:0] D,
  input  logic         EN,
  output logic [N-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (!n_Reset) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter sharing one d_ffN storage register between M writers.
module pipo_write_arbiter
  import pipo_arb_pkg::*;
#(
  parameter  int unsigned N = 8,
  parameter  int unsigned M = 4,
  localparam int unsigned W = $clog2(M)
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] wdata,
  output logic [M-1:0]   gnt,
  output logic [M-1:0]   ack,
  output logic [W-1:0]   owner,
  output logic           busy,
  output logic [N-1:0]   Q
);

  arb_state_t     state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   owner_q, owner_d;
  logic [W-1:0]   pick;
  logic [W-1:0]   idx;
  logic           found;
  logic [M-1:0]   owner_oh;
  logic [N-1:0]   reg_d;
  logic           reg_en;

  // Rotating-priority scan starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 0; i < int'(M); i++) begin
      idx = W'((32'(ptr_q) + 32'(i)) % M);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req[owner_q]) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
          ptr_d   = W'(next_ptr(32'(owner_q), M));
        end
      end
      WRITE: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        ptr_d   = W'(next_ptr(32'(owner_q), M));
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears Q through the data path since the register's own reset is tied off.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    gnt               = '0;
    ack               = '0;
    reg_en            = Reset;
    reg_d             = '0;
    unique case (state_q)
      GRANT: gnt = owner_oh;
      WRITE: begin
        gnt    = owner_oh;
        reg_en = 1'b1;
        if (!Reset) begin
          reg_d = wdata[32'(owner_q)*N +: N];
        end
      end
      ACK:     ack = owner_oh;
      default: ;
    endcase
  end

  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

  d_ffN #(
    .N(N)
  ) u_store (
    .CLK    (CLK),
    .n_Reset(1'b1),
    .D      (reg_d),
    .EN     (reg_en),
    .Q      (Q)
  );

endmodule
